// File: rtl/kernel_kcore_ctrl_pkg.sv
// Shared types and sizing helpers for the kcore dataflow start/done sequencer.
package kernel_kcore_ctrl_pkg;

    // Region status: IDLE means nothing accepted-but-unretired.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } region_state_e;

    localparam int NUM_PROC_DEF     = 4;
    localparam int MAX_INFLIGHT_DEF = 4;

    // Bits needed for a counter spanning 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/kernel_kcore_done_tracker.sv
// Per-process done counter: buffers child ap_done pulses until every process
// has finished the same iteration, and throttles the child when full.
module kernel_kcore_done_tracker
    import kernel_kcore_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = cnt_width(MAX_INFLIGHT)
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic proc_done,
    input  logic iter_cmpl,
    output logic proc_continue,
    output logic nonzero
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] done_cnt_next;
    logic             inc;

    // A done offered while proc_continue is low is a protocol error and is dropped.
    assign proc_continue = (done_cnt < MAX_CNT);
    assign nonzero       = (done_cnt != '0);
    assign inc           = proc_done & proc_continue;

    // Next count: increment on accepted done, decrement on region completion.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        done_cnt_next = done_cnt;
        case ({inc, iter_cmpl})
            2'b10:   done_cnt_next = done_cnt + ONE;
            2'b01:   done_cnt_next = done_cnt - ONE;
            default: done_cnt_next = done_cnt;
        endcase
    end

    // Count register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: sequential state uses <= so all registers sample pre-edge values together.
        if (!ap_rst_n) done_cnt <= '0;
        else           done_cnt <= done_cnt_next;
    end

    a_cnt_max:   assert property (@(posedge ap_clk) disable iff (!ap_rst_n) done_cnt <= MAX_CNT);
    a_no_under:  assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(iter_cmpl && !nonzero));

endmodule

// File: rtl/kernel_kcore_dataflow_start_ctrl.sv
// Start/done sequencer for the kcore dataflow region: accepts ap_start
// iterations, fans a start token out to each child start FIFO, gathers child
// dones into whole-iteration completions, and reports ap_done/ap_idle.
module kernel_kcore_dataflow_start_ctrl
    import kernel_kcore_ctrl_pkg::*;
#(
    parameter int NUM_PROC     = NUM_PROC_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = cnt_width(MAX_INFLIGHT)
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic                ap_continue,
    output logic                ap_idle,
    input  logic [NUM_PROC-1:0] start_full_n,
    output logic [NUM_PROC-1:0] start_write,
    input  logic [NUM_PROC-1:0] proc_done,
    output logic [NUM_PROC-1:0] proc_continue
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NUM_PROC-1:0] pending;
    logic [NUM_PROC-1:0] pending_next;
    logic [NUM_PROC-1:0] token;
    logic [NUM_PROC-1:0] proc_nonzero;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    inflight_next;
    logic [CNT_W-1:0]    cmpl;
    logic [CNT_W-1:0]    cmpl_next;
    logic                acc;
    logic                retire;
    logic                iter_cmpl;
    region_state_e       state;
    region_state_e       state_next;

    assign ap_done  = (cmpl != '0);
    assign retire   = ap_done & ap_continue;

    // A retirement in the same cycle frees a slot, so a full region can still accept.
    assign acc      = ap_start & (pending == '0) & ((inflight < MAX_CNT) | retire);
    assign ap_ready = acc;

    // The new iteration's tokens are offered in the accept cycle itself.
    assign token        = pending | {NUM_PROC{acc}};
    assign start_write  = token & start_full_n;
    assign pending_next = token & ~start_write;

    assign iter_cmpl = (&proc_nonzero) & (cmpl < MAX_CNT);

    // state is IDLE exactly when inflight is zero.
    assign ap_idle = (state == ST_IDLE) & (pending == '0);

    for (genvar i = 0; i < NUM_PROC; i++) begin : g_trk
        kernel_kcore_done_tracker #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CNT_W        (CNT_W)
        ) u_trk (
            .ap_clk        (ap_clk),
            .ap_rst_n      (ap_rst_n),
            .proc_done     (proc_done[i]),
            .iter_cmpl     (iter_cmpl),
            .proc_continue (proc_continue[i]),
            .nonzero       (proc_nonzero[i])
        );
    end

    // Iteration bookkeeping: simultaneous inc/dec nets to no change.
    always_comb begin
        inflight_next = inflight;
        cmpl_next     = cmpl;
        case ({acc, retire})
            2'b10:   inflight_next = inflight + ONE;
            2'b01:   inflight_next = inflight - ONE;
            default: inflight_next = inflight;
        endcase
        case ({iter_cmpl, retire})
            2'b10:   cmpl_next = cmpl + ONE;
            2'b01:   cmpl_next = cmpl - ONE;
            default: cmpl_next = cmpl;
        endcase
    end

    // Region status next-state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (acc) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (inflight_next == '0) state_next = ST_IDLE;
                else if (!ap_start)      state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight_next == '0) state_next = ST_IDLE;
                else if (acc)            state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Token, counter and status registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pending  <= '0;
            inflight <= '0;
            cmpl     <= '0;
            state    <= ST_IDLE;
        end else begin
            pending  <= pending_next;
            inflight <= inflight_next;
            cmpl     <= cmpl_next;
            state    <= state_next;
        end
    end

    a_inflight_max: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) inflight <= MAX_CNT);
    a_cmpl_le_infl: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) cmpl <= inflight);
    a_no_full_wr:   assert property (@(posedge ap_clk) disable iff (!ap_rst_n) (start_write & ~start_full_n) == '0);
    a_idle_state:   assert property (@(posedge ap_clk) disable iff (!ap_rst_n) (state == ST_IDLE) == (inflight == '0));

endmodule

// File: tb/tb_kernel_kcore_dataflow_start_ctrl.sv
// Bench for kernel_kcore_dataflow_start_ctrl. The reference model keeps
// cumulative event totals since reset (iterations accepted, tokens sent per
// FIFO, dones per child, iterations completed, iterations retired) and derives
// every expected output from differences of those totals.
module tb_kernel_kcore_dataflow_start_ctrl;

    localparam int NP   = 4;
    localparam int MAXI = 4;
    localparam int VW   = 3 + 2 * NP;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_continue;
    logic [NP-1:0] start_full_n;
    logic [NP-1:0] proc_done;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [NP-1:0] start_write;
    logic [NP-1:0] proc_continue;

    int n_vec = 0;
    int n_err = 0;

    int acc_total, ret_total, cmpl_total;
    int sent  [NP];
    int dones [NP];

    logic [VW-1:0] exp_vec, act_vec;

    kernel_kcore_dataflow_start_ctrl #(.NUM_PROC(NP), .MAX_INFLIGHT(MAXI)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .ap_idle       (ap_idle),
        .start_full_n  (start_full_n),
        .start_write   (start_write),
        .proc_done     (proc_done),
        .proc_continue (proc_continue)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic model_reset();
        acc_total = 0; ret_total = 0; cmpl_total = 0;
        for (int i = 0; i < NP; i++) begin
            sent[i]  = 0;
            dones[i] = 0;
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
        start_full_n = '1; proc_done = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs at negedge, predict outputs, capture DUT outputs
    // before the next posedge, then advance the model totals. Child dones are
    // only driven when legal (child holds an unfinished token, continue high).
    task automatic cycle(input logic s, input logic c, input logic [NP-1:0] fn,
                         input logic [NP-1:0] pd);
        logic [NP-1:0] pend, pcont, pdl, e_wr;
        logic nopend, e_done, e_ret, e_ready, all_nz, e_iter, e_idle;
        @(negedge ap_clk);
        nopend = 1'b1;
        for (int i = 0; i < NP; i++) begin
            pend[i]  = (acc_total != sent[i]);
            if (pend[i]) nopend = 1'b0;
            pcont[i] = (dones[i] - cmpl_total) < MAXI;
            pdl[i]   = pd[i] && pcont[i] && (sent[i] - dones[i] > 0);
        end
        ap_start = s; ap_continue = c; start_full_n = fn; proc_done = pdl;
        #2;
        e_done  = (cmpl_total - ret_total) > 0;
        e_ret   = e_done && c;
        e_ready = s && nopend && (((acc_total - ret_total) < MAXI) || e_ret);
        all_nz  = 1'b1;
        for (int i = 0; i < NP; i++) begin
            e_wr[i] = (pend[i] || e_ready) && fn[i];
            if (dones[i] - cmpl_total == 0) all_nz = 1'b0;
        end
        e_iter = all_nz && ((cmpl_total - ret_total) < MAXI);
        e_idle = (acc_total == ret_total) && nopend;
        exp_vec = {e_ready, e_done, e_idle, e_wr, pcont};
        act_vec = {ap_ready, ap_done, ap_idle, start_write, proc_continue};
        acc_total += int'(e_ready);
        for (int i = 0; i < NP; i++) begin
            sent[i]  += int'(e_wr[i]);
            dones[i] += int'(pdl[i]);
        end
        cmpl_total += int'(e_iter);
        ret_total  += int'(e_ret);
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b1, 1'b0, '1, '0);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL reset_pre0: got %b want %b", act_vec, exp_vec); end
        cycle(1'b0, 1'b0, '1, '1);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL reset_pre1: got %b want %b", act_vec, exp_vec); end
        @(posedge ap_clk);
        #3;
        ap_start = 1'b0; ap_continue = 1'b0; proc_done = '0;
        ap_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ap_ready, ap_done, ap_idle, start_write, proc_continue} !== {3'b001, {NP{1'b0}}, {NP{1'b1}}}) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", {ap_ready, ap_done, ap_idle, start_write, proc_continue},
                     {3'b001, {NP{1'b0}}, {NP{1'b1}}});
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, '1, '0);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL reset_post: got %b want %b", act_vec, exp_vec); end
    endtask

    task automatic test_single_iter();
        logic [NP-1:0] pd;
        int first_done = -1;
        do_reset();
        for (int cyc = 1; cyc <= 14; cyc++) begin
            pd = '0;
            if (cyc == 3) pd = 4'b0001;
            if (cyc == 5) pd = 4'b0010;
            if (cyc == 6) pd = 4'b0100;
            if (cyc == 9) pd = 4'b1000;
            cycle(cyc == 1, cyc == 12, '1, pd);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL single cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
            if (cyc == 1) begin
                n_vec++;
                if ({ap_ready, start_write} !== 5'b11111) begin
                    n_err++; $display("FAIL single_accept: got %b want 11111", {ap_ready, start_write});
                end
            end
            if (ap_done && first_done < 0) first_done = cyc;
        end
        // Last done in cycle 9 is counted at that edge, completes in cycle 10, reports in 11.
        n_vec++;
        if (first_done != 11) begin n_err++; $display("FAIL single_done_cycle: got %0d want 11", first_done); end
    endtask

    task automatic test_backpressure();
        int bit2_early = 0;
        int second_ready = -1;
        do_reset();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            cycle(1'b1, 1'b0, (cyc <= 5) ? 4'b1011 : 4'b1111, '0);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL backpr cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
            if (cyc <= 5 && start_write[2]) bit2_early++;
            if (cyc > 1 && ap_ready && second_ready < 0) second_ready = cyc;
        end
        n_vec++;
        if (bit2_early != 0) begin n_err++; $display("FAIL backpr_full_write: got %0d want 0", bit2_early); end
        n_vec++;
        if (second_ready != 7) begin n_err++; $display("FAIL backpr_second_ready: got %0d want 7", second_ready); end
    endtask

    task automatic test_inflight_limit();
        int readies = 0;
        int k;
        logic hit = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            cycle(1'b1, 1'b0, '1, '0);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL limit_fill cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
            if (ap_ready) readies++;
        end
        n_vec++;
        if (readies != MAXI) begin n_err++; $display("FAIL limit_count: got %0d want %0d", readies, MAXI); end
        cycle(1'b1, 1'b1, '1, '1);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL limit_done: got %b want %b", act_vec, exp_vec); end
        for (k = 0; k < 10 && !hit; k++) begin
            cycle(1'b1, 1'b1, '1, '0);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL limit_retire k%0d: got %b want %b", k, act_vec, exp_vec); end
            if (ap_ready) begin
                hit = 1'b1;
                n_vec++;
                if (ap_done !== 1'b1) begin n_err++; $display("FAIL limit_same_cycle: got ap_done=%b want 1", ap_done); end
            end
        end
        n_vec++;
        if (!hit) begin n_err++; $display("FAIL limit_fifth_accept: got none in %0d cycles want 1", k); end
        for (int cyc = 0; cyc < 4; cyc++) begin
            cycle(1'b1, 1'b0, '1, '0);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL limit_hold cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
    endtask

    task automatic test_done_hold();
        int readies = 0;
        int rets = 0;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            cycle(readies < MAXI, 1'b0, '1, '0);
            if (ap_ready) readies++;
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL hold_fill cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            cycle(1'b0, 1'b0, '1, 4'b0001);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL hold_p0 cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        n_vec++;
        if (proc_continue[0] !== 1'b0) begin n_err++; $display("FAIL hold_p0_throttle: got %b want 0", proc_continue[0]); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            cycle(1'b0, 1'b0, '1, 4'b1110);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL hold_wait cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        n_vec++;
        if (ap_done !== 1'b1) begin n_err++; $display("FAIL hold_done_held: got %b want 1", ap_done); end
        for (int cyc = 0; cyc < 7; cyc++) begin
            cycle(1'b0, 1'b1, '1, '0);
            if (ap_done) rets++;
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL hold_drain cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        n_vec++;
        if (rets != MAXI) begin n_err++; $display("FAIL hold_retire_count: got %0d want %0d", rets, MAXI); end
        n_vec++;
        if (ap_idle !== 1'b1) begin n_err++; $display("FAIL hold_idle: got %b want 1", ap_idle); end
    endtask

    task automatic test_simultaneous();
        int readies = 0;
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            cycle(readies < 3, 1'b0, '1, '0);
            if (ap_ready) readies++;
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_fill cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        // Processes 0..2 finish all three iterations, process 3 only the first.
        for (int cyc = 0; cyc < 3; cyc++) begin
            cycle(1'b0, 1'b0, '1, (cyc == 0) ? 4'b1111 : 4'b0111);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_done cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            cycle(1'b0, 1'b0, '1, '0);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_wait cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        cycle(1'b0, 1'b0, '1, 4'b1000);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_pre: got %b want %b", act_vec, exp_vec); end
        // Completion of iteration 2, retirement of 1, last done of 3 and a new accept together.
        cycle(1'b1, 1'b1, '1, 4'b1000);
        n_vec++;
        if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_edge: got %b want %b", act_vec, exp_vec); end
        n_vec++;
        if ({ap_ready, ap_done} !== 2'b11) begin n_err++; $display("FAIL simul_ready_done: got %b want 11", {ap_ready, ap_done}); end
        cycle(1'b0, 1'b0, '1, '0);
        n_vec++;
        if (ap_done !== 1'b1) begin n_err++; $display("FAIL simul_cmpl_kept: got %b want 1", ap_done); end
        for (int cyc = 0; cyc < 16; cyc++) begin
            cycle(1'b0, 1'b1, '1, '1);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL simul_drain cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
        n_vec++;
        if (ap_idle !== 1'b1) begin n_err++; $display("FAIL simul_idle: got %b want 1", ap_idle); end
    endtask

    task automatic test_random();
        logic [NP-1:0] fn, pd;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NP; i++) begin
                fn[i] = ($urandom_range(3) != 0);
                pd[i] = ($urandom_range(2) == 0);
            end
            cycle(($urandom_range(3) != 0), ($urandom_range(2) == 0), fn, pd);
            n_vec++;
            if (act_vec !== exp_vec) begin n_err++; $display("FAIL random cyc%0d: got %b want %b", cyc, act_vec, exp_vec); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_iter();
        test_backpressure();
        test_inflight_limit();
        test_done_hold();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
